branch_predictor: RTL



---
 rtl/branch_predictor.sv | 118 +++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//   IF-stage next-PC predictor: direct-mapped BTB (tag + target) combined with
//   a gshare pattern history table of 2-bit saturating counters. Prediction is
//   purely combinational from current_pc; the tables and the global history
//   register learn from the EX-stage resolver on the clock edge.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   current_pc        PC being fetched this cycle
//   next_pc           predicted next fetch PC
//   pred_taken        1 when the BTB target is used
//   pred_ghr          history snapshot used for this prediction (travels with
//                     the instruction and returns as update_ghr)
//   update_en         resolver has a valid branch/jal/jalr outcome this cycle
//   update_is_cond    1 = conditional branch, 0 = jal/jalr
//   update_pc         PC of the resolved instruction
//   update_taken      actual direction
//   update_target     resolved taken target
//   update_ghr        pred_ghr carried with the resolved instruction
// ---------------------------------------------------------------------------
module branch_predictor #(
  parameter int         IDX_BITS  = 5,
  parameter logic [1:0] RESET_CNT = 2'b01
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         current_pc,
  output logic [31:0]         next_pc,
  output logic                pred_taken,
  output logic [IDX_BITS-1:0] pred_ghr,
  input  logic                update_en,
  input  logic                update_is_cond,
  input  logic [31:0]         update_pc,
  input  logic                update_taken,
  input  logic [31:0]         update_target,
  input  logic [IDX_BITS-1:0] update_ghr
);

  localparam int ENTRIES  = 1 << IDX_BITS;
  localparam int TAG_BITS = 32 - IDX_BITS - 2;

  logic [ENTRIES-1:0]  btb_valid;
  logic [TAG_BITS-1:0] btb_tag    [ENTRIES];
  logic [31:0]         btb_target [ENTRIES];
  logic [1:0]          pht        [ENTRIES];
  logic [IDX_BITS-1:0] ghr;

  // ---------------- lookup ----------------
  logic [IDX_BITS-1:0] lk_bidx;
  logic [IDX_BITS-1:0] lk_pidx;
  logic [TAG_BITS-1:0] lk_tag;
  logic                lk_hit;

  assign lk_bidx = current_pc[IDX_BITS+1:2];
  assign lk_tag  = current_pc[31:IDX_BITS+2];
  assign lk_pidx = lk_bidx ^ ghr;
  assign lk_hit  = btb_valid[lk_bidx] && (btb_tag[lk_bidx] == lk_tag);

  assign pred_taken = lk_hit && pht[lk_pidx][1];
  assign next_pc    = pred_taken ? btb_target[lk_bidx] : current_pc + 32'd4;
  assign pred_ghr   = ghr;

  // ---------------- update ----------------
  logic [IDX_BITS-1:0] up_bidx;
  logic [IDX_BITS-1:0] up_pidx;
  logic [TAG_BITS-1:0] up_tag;
  logic [1:0]          pht_cur;
  logic [1:0]          pht_new;

  assign up_bidx = update_pc[IDX_BITS+1:2];
  assign up_tag  = update_pc[31:IDX_BITS+2];
  // The counter is indexed with the history the instruction was predicted
  // with, not the live GHR, so training hits the entry that made the guess.
  assign up_pidx = up_bidx ^ update_ghr;
  assign pht_cur = pht[up_pidx];

  // NOTE: every branch of a combinational block must assign its outputs;
  // the default first keeps a missing case from inferring a latch.
  always_comb begin
    pht_new = pht_cur;
    if (!update_is_cond) begin
      pht_new = 2'b11;                     // jal/jalr are always taken
    end else if (update_taken) begin
      if (pht_cur != 2'b11) pht_new = pht_cur + 2'd1;
    end else begin
      if (pht_cur != 2'b00) pht_new = pht_cur - 2'd1;
    end
  end

  // Control state: valid bits, counters and history must come out of reset
  // in a known state. Reset wins over a simultaneous update.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; this also gives read-before-write behaviour for
  // a same-cycle lookup and update of one entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      btb_valid <= '0;
      ghr       <= '0;
      for (int i = 0; i < ENTRIES; i++) pht[i] <= RESET_CNT;
    end else if (update_en) begin
      pht[up_pidx] <= pht_new;
      if (update_taken) btb_valid[up_bidx] <= 1'b1;
      // History is trained at resolve time only, so it never needs repair.
      if (update_is_cond) ghr <= {ghr[IDX_BITS-2:0], update_taken};
    end
  end

  // NOTE: tag/target payload is not reset; it is unreachable until the
  // matching valid bit is set, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (!reset && update_en && update_taken) begin
      btb_tag[up_bidx]    <= up_tag;
      btb_target[up_bidx] <= update_target;
    end
  end

endmodule
